sram_copy_engine: RTL and testbench

SRAM_COPY_ENGINE -- requirements
Module: sram_copy_engine

---
 rtl/sram_copy_engine.sv | 137 +++++++++++++
 tb/tb_sram_copy_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_copy_engine.sv
// sram_copy_engine
//
// Copies a block of words inside one single-port SRAM. Each word needs two
// cycles: a READ cycle that presents the source address, then a WRITE cycle
// that stores the registered read data (mem_q) at the destination address.
// Both pointers wrap modulo the SRAM size. A zero-length request produces a
// done pulse without touching memory.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     copy request, sampled only while idle
//   src_addr  first source word address
//   dst_addr  first destination word address
//   length    number of words to copy, 0 .. 2**ADDR_WIDTH
//   busy      high while a copy is in progress
//   done      one-cycle completion pulse
//   mem_addr  SRAM address (combinational from state and pointers)
//   mem_we    SRAM write enable
//   mem_data  SRAM write data
//   mem_q     SRAM registered read data, valid the cycle after the address
module sram_copy_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  done_q;

  logic accept;
  logic last_word;

  assign accept    = (state == IDLE) && start && (length != LEN_ZERO);
  assign last_word = (remaining == LEN_ONE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers, word counter and the registered done pulse. done is set on
  // the edge that leaves WRITE for the last word, or on the edge that
  // samples a zero-length request, so it appears one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= length;
          end else if (start) begin
            done_q <= 1'b1;
          end
        end
        WRITE: begin
          src_ptr   <= src_ptr + PTR_ONE;
          dst_ptr   <= dst_ptr + PTR_ONE;
          remaining <= remaining - LEN_ONE;
          done_q    <= last_word;
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs: purely combinational so the SRAM sees the access in
  // the same cycle as the state. Reset forces IDLE, which zeroes them at once.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_data = '0;
    case (state)
      READ: begin
        mem_addr = src_ptr;
      end
      WRITE: begin
        mem_addr = dst_ptr;
        mem_we   = 1'b1;
        mem_data = mem_q;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_sram_copy_engine.sv
module tb_sram_copy_engine;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;

  int checks = 0;
  int errors = 0;

  // Bench SRAM and the expected image of it.
  logic [DW-1:0] sram    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  sram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_data (mem_data),
    .mem_q    (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-write SRAM with registered read (old data on collision).
  always @(posedge clk) begin
    mem_q <= sram[mem_addr];
    if (mem_we) sram[mem_addr] = mem_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (sram[a] !== ref_mem[a]) bad++;
    chk(name, bad, 0);
  endtask

  // Reference: ascending word-by-word copy with wrap; overlap falls out naturally.
  task automatic model_copy(input int src, input int dst, input int len);
    for (int i = 0; i < len; i++)
      ref_mem[(dst + i) % DEPTH] = ref_mem[(src + i) % DEPTH];
  endtask

  task automatic preload(input int base, input int len, input logic [DW-1:0] pat);
    logic [DW-1:0] v;
    for (int i = 0; i < len; i++) begin
      v = pat + DW'(i);
      sram[(base + i) % DEPTH]    = v;
      ref_mem[(base + i) % DEPTH] = v;
    end
  endtask

  // One complete request; observes every cycle until a few past the expected end.
  task automatic do_copy(input int src, input int dst, input int len,
                         input int exp_done, input string name);
    int done_cyc, done_cnt, busy_bad, rd_bad, wr_bad, nrd, nwr, budget;
    logic [31:0] s, d, l;
    s = src; d = dst; l = len;
    done_cyc = -1; done_cnt = 0; busy_bad = 0; rd_bad = 0; wr_bad = 0;
    nrd = 0; nwr = 0;
    budget = 2 * len + 4;
    @(posedge clk); #1;
    start = 1'b1; src_addr = s[AW-1:0]; dst_addr = d[AW-1:0]; length = l[AW:0];
    @(posedge clk); #1;   // edge 0 has sampled the request
    start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (busy !== ((k >= 1) && (k <= 2 * len))) busy_bad++;
      if (mem_we === 1'b1) begin
        if (mem_addr !== AW'((dst + nwr) % DEPTH) || k != 2 * (nwr + 1)) wr_bad++;
        nwr++;
      end else if (busy === 1'b1) begin
        if (mem_addr !== AW'((src + nrd) % DEPTH) || k != 2 * nrd + 1) rd_bad++;
        nrd++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
    end
    model_copy(src, dst, len);
    chk({name, " done_cycle"}, done_cyc, exp_done);
    chk({name, " done_pulses"}, done_cnt, 1);
    chk({name, " busy_profile"}, busy_bad, 0);
    chk({name, " writes"}, nwr, len);
    chk({name, " write_order"}, wr_bad, 0);
    chk({name, " read_order"}, rd_bad, 0);
    chk_mem({name, " sram_image"});
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    int            len;
    logic          use_pat;
    logic [DW-1:0] pat;
    int            exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s, d, l;
    int busy_cnt, done_cnt, bad;
    int exp_wa[5];
    int exp_wc[5];
    int nw;

    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    for (int a = 0; a < DEPTH; a++) begin
      sram[a]    = DW'($urandom);
      ref_mem[a] = sram[a];
    end

    vecs[0] = '{12'h010, 12'h020, 1,    1'b1, 16'hBEEF, 3};
    vecs[1] = '{12'h100, 12'h200, 8,    1'b1, 16'h1000, 17};
    vecs[2] = '{12'h050, 12'h060, 0,    1'b0, 16'h0000, 1};
    vecs[3] = '{12'hFFE, 12'h7FF, 4,    1'b0, 16'h0000, 9};
    vecs[4] = '{12'h700, 12'h702, 6,    1'b1, 16'h7700, 13};
    vecs[5] = '{12'hABC, 12'hABC, 3,    1'b0, 16'h0000, 7};
    vecs[6] = '{12'h123, 12'h923, 4096, 1'b0, 16'h0000, 8193};

    // Reset state
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_data", mem_data, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].use_pat) preload(vecs[i].src, vecs[i].len, vecs[i].pat);
      do_copy(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].exp_done,
              $sformatf("vec%0d", i));
      if (i == 0) chk("vec0 sram[020]", sram[12'h020], 16'hBEEF);
    end

    // Randomized copies
    for (int r = 0; r < 8; r++) begin
      s = $urandom_range(0, DEPTH - 1);
      d = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 40);
      do_copy(s, d, l, 2 * l + 1, $sformatf("rand%0d", r));
    end

    // Start while busy is ignored; start held in the done cycle launches a second copy.
    exp_wa = '{'h340, 'h341, 'h342, 'h540, 'h541};
    exp_wc = '{2, 4, 6, 9, 11};
    busy_cnt = 0; done_cnt = 0; bad = 0; nw = 0;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 12'h300; dst_addr = 12'h340; length = 13'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy !== (((k >= 1) && (k <= 6)) || ((k >= 8) && (k <= 11)))) bad++;
      if (done !== ((k == 7) || (k == 12))) bad++;
      if (mem_we === 1'b1) begin
        if (nw < 5) begin
          if (mem_addr !== AW'(exp_wa[nw]) || k != exp_wc[nw]) bad++;
        end
        nw++;
      end
      if (k == 8) chk("b2b busy_after_done", busy, 1);
      if (k == 2) begin
        start = 1'b1; src_addr = 12'h500; dst_addr = 12'h540; length = 13'd2;
      end
      if (k == 8) start = 1'b0;
    end
    model_copy('h300, 'h340, 3);
    model_copy('h500, 'h540, 2);
    chk("b2b profile", bad, 0);
    chk("b2b writes", nw, 5);
    chk_mem("b2b sram_image");

    // Reset in the middle of a copy (cycle 6 is the WRITE of word 2).
    preload('h600, 8, 16'h6600);
    // Give the destination of word 2 the value it would receive, so the image
    // is the same whether or not that aborted write lands.
    sram['h642] = 16'h6602; ref_mem['h642] = 16'h6602;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 12'h600; dst_addr = 12'h640; length = 13'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("rst mid we_before", mem_we, 1);
    chk("rst mid addr_before", mem_addr, 12'h642);
    reset_n = 1'b0;
    #1;
    chk("rst mid busy", busy, 0);
    chk("rst mid mem_we", mem_we, 0);
    chk("rst mid mem_addr", mem_addr, 0);
    chk("rst mid mem_data", mem_data, 0);
    chk("rst mid done", done, 0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    chk("rst mid no_done", done_cnt, 0);
    chk("rst mid idle_after", busy_cnt, 0);
    model_copy('h600, 'h640, 2);
    chk_mem("rst mid sram_image");

    // Normal operation after reset release
    do_copy('h0F0, 'h0E0, 5, 11, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
